// File: rtl/fp_sqrt_iter_if.sv
// Handshake bundle for fp_sqrt_iter: operand channel in, result channel out.
// The master side supplies operands and consumes results.
interface fp_sqrt_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         invalid;
  logic         inexact;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, c, invalid, inexact
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, c, invalid, inexact
  );
endinterface

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754 square root: one restoring root bit per clock, round to
// nearest, subnormals flushed, NaN/inf/negative operands resolved at acceptance.
module fp_sqrt_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          clk,
  input  logic          rst,
  fp_sqrt_iter_if.slave s
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int ITER = MAN_W + 2;
  localparam int RADW = 2 * ITER;
  localparam int REMW = ITER + 2;
  localparam int CNTW = $clog2(ITER);
  localparam logic [EXP_W:0] BIAS = {2'b00, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_invalid;
  logic              r_inexact;
  logic [W-1:0]      r_c;
  logic [CNTW-1:0]   r_cnt;
  logic [RADW-1:0]   r_rad;
  logic [REMW-1:0]   r_rem;
  logic [ITER-1:0]   r_root;
  logic [EXP_W-1:0]  r_exp;

  logic              w_sign;
  logic [EXP_W-1:0]  w_exp;
  logic [MAN_W-1:0]  w_frac;
  logic              w_exp_zero;
  logic              w_exp_ones;
  logic              w_frac_nz;
  logic              w_normal;
  logic [RADW-1:0]   w_rad_init;
  logic [EXP_W:0]    w_res_exp;
  logic [REMW+1:0]   w_shift_rem;
  logic signed [ITER+4:0] w_trial;
  logic              w_keep;
  logic [MAN_W:0]    w_round;
  logic              w_unused;

  // Guard bit alone decides rounding: a square root can never land on a tie.
  function automatic logic [MAN_W:0] f_round(input logic [ITER-1:0] root);
    return root[ITER-1:1] + {{MAN_W{1'b0}}, root[0]};
  endfunction

  assign w_sign     = s.a[W-1];
  assign w_exp      = s.a[W-2:MAN_W];
  assign w_frac     = s.a[MAN_W-1:0];
  assign w_exp_zero = (w_exp == '0);
  assign w_exp_ones = &w_exp;
  assign w_frac_nz  = |w_frac;
  assign w_normal   = !w_exp_zero && !w_exp_ones && !w_sign;

  // Odd biased exponent means an even unbiased one; otherwise double the operand.
  assign w_rad_init = w_exp[0] ? {1'b0, 1'b1, w_frac, {(RADW-MAN_W-2){1'b0}}}
                               : {1'b1, w_frac, {(RADW-MAN_W-1){1'b0}}};
  assign w_res_exp  = ({1'b0, w_exp} + BIAS) >> 1;

  assign w_shift_rem = {r_rem, r_rad[RADW-1 -: 2]};
  assign w_trial     = $signed({1'b0, w_shift_rem}) - $signed({3'b000, r_root, 2'b01});
  assign w_keep      = ~w_trial[ITER+4];
  assign w_round     = f_round(r_root);

  assign w_unused = ^{w_trial[ITER+3:REMW], w_shift_rem[REMW+1:REMW], w_res_exp[EXP_W],
                      w_round[MAN_W]};

  assign s.in_ready  = r_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.c         = r_c;
  assign s.invalid   = r_invalid;
  assign s.inexact   = r_inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_invalid   <= 1'b0;
      r_inexact   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s.in_valid) begin
            r_in_ready <= 1'b0;
            r_inexact  <= 1'b0;
            r_invalid  <= 1'b0;
            if (w_normal) begin
              r_state <= CALC;
              r_cnt   <= CNTW'(ITER - 1);
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              if (w_exp_zero) begin
                r_c <= {w_sign, {(W-1){1'b0}}};
              end else if (w_exp_ones && w_frac_nz) begin
                r_c       <= QNAN;
                r_invalid <= 1'b1;
              end else if (!w_sign) begin
                r_c <= s.a;
              end else begin
                r_c       <= QNAN;
                r_invalid <= 1'b1;
              end
            end
          end
        end
        CALC: begin
          if (r_cnt == '0) r_state <= ROUND;
          else             r_cnt   <= r_cnt - CNTW'(1);
        end
        ROUND: begin
          r_c         <= {1'b0, r_exp, w_round[MAN_W-1:0]};
          r_inexact   <= r_root[0] | (|r_rem);
          r_invalid   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (s.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath carries no reset: it is always reloaded before it is consumed.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && s.in_valid && w_normal) begin
      r_rad  <= w_rad_init;
      r_rem  <= '0;
      r_root <= '0;
      r_exp  <= w_res_exp[EXP_W-1:0];
    end else if (r_state == CALC) begin
      r_rad  <= r_rad << 2;
      r_rem  <= w_keep ? w_trial[REMW-1:0] : w_shift_rem[REMW-1:0];
      r_root <= {r_root[ITER-2:0], w_keep};
    end
  end
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Scoreboard bench for fp_sqrt_iter: single- and half-precision instances,
// directed corner operands plus random operands against an integer-sqrt model.
module tb_fp_sqrt_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sqrt_iter_if #(.EXP_W(8), .MAN_W(23)) ifs ();
  fp_sqrt_iter_if #(.EXP_W(5), .MAN_W(10)) ifh ();

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst(rst), .s(ifs));
  fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst(rst), .s(ifh));

  typedef struct packed {
    logic [31:0] c;
    logic        inv;
    logic        inx;
  } exp_t;

  localparam int NRAND = 300;

  exp_t qs[$];
  exp_t qh[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   hp_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference: exact integer square root of the scaled significand, then round.
  function automatic void ref_sqrt(input int ew, input int mw, input longint a,
                                   output longint c, output logic inv, output logic inx);
    longint bias, ones, sgn, ex, fr, qnan, m, n, q, lo, hi, mid;
    int e, re;
    bias = (longint'(1) << (ew - 1)) - 1;
    ones = (longint'(1) << ew) - 1;
    sgn  = (a >> (ew + mw)) & 1;
    ex   = (a >> mw) & ones;
    fr   = a & ((longint'(1) << mw) - 1);
    qnan = (ones << mw) | (longint'(1) << (mw - 1));
    inv  = 1'b0;
    inx  = 1'b0;
    if (ex == 0) begin
      c = sgn << (ew + mw);
    end else if (ex == ones && fr != 0) begin
      c = qnan; inv = 1'b1;
    end else if (ex == ones && sgn == 0) begin
      c = a;
    end else if (sgn != 0) begin
      c = qnan; inv = 1'b1;
    end else begin
      e = int'(ex - bias);
      m = (longint'(1) << mw) + fr;
      if (e % 2 == 0) begin
        n = m << mw;        re = e / 2;
      end else begin
        n = m << (mw + 1);  re = (e - 1) / 2;
      end
      lo = 0;
      hi = longint'(1) << (mw + 2);
      while (lo < hi) begin
        mid = (lo + hi + 1) >> 1;
        if (mid * mid <= n) lo = mid;
        else                hi = mid - 1;
      end
      q   = lo;
      inx = (q * q != n);
      if (4 * n > (2 * q + 1) * (2 * q + 1)) q = q + 1;
      if (q == (longint'(1) << (mw + 1))) begin
        q = q >> 1; re = re + 1;
      end
      c = (longint'(re + int'(bias)) << mw) | (q & ((longint'(1) << mw) - 1));
    end
  endfunction

  task automatic mon_sp();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ifs.out_valid && ifs.out_ready) begin
        if (qs.size() == 0) fail_event("sp_unexpected_out", $sformatf("c=%08h with nothing pending", ifs.c));
        else begin
          e = qs.pop_front();
          check("sp_c", 64'(ifs.c), 64'(e.c));
          check("sp_invalid", 64'(ifs.invalid), 64'(e.inv));
          check("sp_inexact", 64'(ifs.inexact), 64'(e.inx));
        end
      end
    end
  endtask

  task automatic mon_hp();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ifh.out_valid && ifh.out_ready) begin
        if (qh.size() == 0) fail_event("hp_unexpected_out", $sformatf("c=%04h with nothing pending", ifh.c));
        else begin
          e = qh.pop_front();
          check("hp_c", 64'(ifh.c), 64'(e.c[15:0]));
          check("hp_invalid", 64'(ifh.invalid), 64'(e.inv));
          check("hp_inexact", 64'(ifh.inexact), 64'(e.inx));
        end
      end
    end
  endtask

  task automatic sp_push_model(input logic [31:0] a);
    longint c; logic inv, inx;
    ref_sqrt(8, 23, longint'(a), c, inv, inx);
    qs.push_back('{c: c[31:0], inv: inv, inx: inx});
  endtask

  task automatic hp_push_model(input logic [15:0] a);
    longint c; logic inv, inx;
    ref_sqrt(5, 10, longint'(a), c, inv, inx);
    qh.push_back('{c: {16'h0, c[15:0]}, inv: inv, inx: inx});
  endtask

  task automatic sp_tick(input bit rnd);
    @(posedge clk); #1;
    if (rnd) ifs.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic hp_tick();
    @(posedge clk); #1;
    ifh.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic sp_issue(input logic [31:0] a, input bit rnd, output bit ok);
    int g = 0;
    while (!ifs.in_ready && g < 300) begin sp_tick(rnd); g++; end
    ok = ifs.in_ready;
    if (!ok) begin
      fail_event("sp_in_ready_timeout", "in_ready=0 after 300 cycles, required 1");
      return;
    end
    ifs.a = a; ifs.in_valid = 1'b1;
    sp_tick(rnd);
    ifs.in_valid = 1'b0;
  endtask

  task automatic sp_directed(input logic [31:0] a, input logic [31:0] ec, input logic ei,
                             input logic ex, input int elat);
    bit ok; int lat;
    ifs.out_ready = 1'b1;
    qs.push_back('{c: ec, inv: ei, inx: ex});
    sp_issue(a, 1'b0, ok);
    if (!ok) return;
    lat = 1;
    while (!ifs.out_valid && lat < 100) begin sp_tick(1'b0); lat++; end
    check($sformatf("sp_latency_%08h", a), 64'(lat), 64'(elat));
    sp_tick(1'b0);
  endtask

  task automatic hp_random();
    logic [15:0] a;
    for (int i = 0; i < NRAND; i++) begin
      int g = 0;
      while (!ifh.in_ready && g < 300) begin hp_tick(); g++; end
      if (!ifh.in_ready) begin
        fail_event("hp_in_ready_timeout", "in_ready=0 after 300 cycles, required 1");
        break;
      end
      if ($urandom_range(0, 9) == 0) a = 16'($urandom);
      else a = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
      hp_push_model(a);
      ifh.a = a; ifh.in_valid = 1'b1;
      hp_tick();
      ifh.in_valid = 1'b0;
    end
    hp_done = 1'b1;
  endtask

  initial begin
    bit ok; bit stable; int seen; logic [31:0] a;
    rst = 1'b1;
    ifs.in_valid = 1'b0; ifs.a = '0; ifs.out_ready = 1'b0;
    ifh.in_valid = 1'b0; ifh.a = '0; ifh.out_ready = 1'b0;
    fork
      mon_sp();
      mon_hp();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(ifs.in_ready), 64'd1);
    check("rst_out_valid", 64'(ifs.out_valid), 64'd0);
    check("rst_c", 64'(ifs.c), 64'd0);
    check("rst_invalid", 64'(ifs.invalid), 64'd0);
    check("rst_inexact", 64'(ifs.inexact), 64'd0);
    check("rst_hp_in_ready", 64'(ifh.in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    sp_tick(1'b0);

    sp_directed(32'h40800000, 32'h40000000, 1'b0, 1'b0, 27);
    sp_directed(32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 27);
    sp_directed(32'h7F7FFFFF, 32'h5F7FFFFF, 1'b0, 1'b1, 27);
    sp_directed(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1);
    sp_directed(32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
    sp_directed(32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 1);
    sp_directed(32'hBF800000, 32'h7FC00000, 1'b1, 1'b0, 1);
    sp_directed(32'h7F800001, 32'h7FC00000, 1'b1, 1'b0, 1);

    // Backpressure: result must hold while a second operand is offered.
    ifs.out_ready = 1'b0;
    qs.push_back('{c: 32'h40400000, inv: 1'b0, inx: 1'b0});
    sp_issue(32'h41100000, 1'b0, ok);
    seen = 0;
    while (!ifs.out_valid && seen < 100) begin sp_tick(1'b0); seen++; end
    check("bp_out_valid", 64'(ifs.out_valid), 64'd1);
    ifs.a = 32'h40800000; ifs.in_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      sp_tick(1'b0);
      if (ifs.c !== 32'h40400000 || ifs.out_valid !== 1'b1 || ifs.in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_hold_stable", 64'(stable), 64'd1);
    ifs.in_valid = 1'b0;
    ifs.out_ready = 1'b1;
    sp_tick(1'b0);
    check("bp_in_ready_after", 64'(ifs.in_ready), 64'd1);
    check("bp_out_valid_after", 64'(ifs.out_valid), 64'd0);

    // Reset during CALC aborts the operation.
    sp_issue(32'h40800000, 1'b0, ok);
    repeat (9) sp_tick(1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(ifs.in_ready), 64'd1);
    check("midrst_out_valid", 64'(ifs.out_valid), 64'd0);
    check("midrst_c", 64'(ifs.c), 64'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (40) begin sp_tick(1'b0); if (ifs.out_valid) seen++; end
    check("midrst_no_out_valid", 64'(seen), 64'd0);
    sp_directed(32'h41800000, 32'h40800000, 1'b0, 1'b0, 27);

    fork
      hp_random();
    join_none
    for (int i = 0; i < NRAND; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      sp_push_model(a);
      sp_issue(a, 1'b1, ok);
      if (!ok) break;
    end

    seen = 0;
    while (!hp_done && seen < 20000) begin sp_tick(1'b1); seen++; end
    check("hp_stream_done", 64'(hp_done), 64'd1);
    ifs.out_ready = 1'b1;
    ifh.out_ready = 1'b1;
    seen = 0;
    while ((qs.size() != 0 || qh.size() != 0) && seen < 200) begin sp_tick(1'b0); seen++; end
    check("sp_queue_drained", 64'(qs.size()), 64'd0);
    check("hp_queue_drained", 64'(qh.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
